// File: rtl/interface_load_store_if.sv
// Datapath-side request/response bundle of the load/store initiator.
// The datapath drives the request and the initiator answers with ready/erro/rdata.
interface interface_load_store_if #(
  parameter int LARGURA = 64
);
  logic               req;
  logic               we;
  logic [2:0]         funct3;
  logic [LARGURA-1:0] addr;
  logic [LARGURA-1:0] wdata;
  logic               ready;
  logic               erro;
  logic [LARGURA-1:0] rdata;

  modport master (
    output req, we, funct3, addr, wdata,
    input  ready, erro, rdata
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output ready, erro, rdata
  );
endinterface

// File: rtl/interface_load_store.sv
// Load/store initiator: turns RISC-V B/H/W/D loads and stores into whole-doubleword
// memory accesses, with read-modify-write for narrow stores and error flagging.
module interface_load_store #(
  parameter int ADDR_DM = 5,
  parameter int LARGURA = 64
) (
  input  logic               clk,
  input  logic               reset,
  interface_load_store_if.slave bus,
  output logic [ADDR_DM-1:0] addrDM,
  output logic               WeDM,
  output logic [LARGURA-1:0] dinDM,
  input  logic [LARGURA-1:0] doutDM
);

  typedef enum logic [1:0] {
    OCIOSO,
    LEITURA,
    ESCRITA,
    CONCLUI
  } state_t;

  state_t stateReg, stateNext;

  logic               weReg;
  logic [2:0]         funct3Reg;
  logic [2:0]         offReg;
  logic [LARGURA-1:0] wdataReg;
  logic               erroReg;
  logic [LARGURA-1:0] rdataReg;
  logic [ADDR_DM-1:0] addrDMReg;
  logic [LARGURA-1:0] dinDMReg;

  logic               illegalReq;
  logic               misalignReq;
  logic               errReq;
  logic [LARGURA-1:0] shiftedWord;
  logic [LARGURA-1:0] loadValue;
  logic [LARGURA-1:0] mergedWord;

  // Request decode works on the live inputs so the first transition already knows the path.
  always_comb begin
    illegalReq  = bus.we ? bus.funct3[2] : (bus.funct3 == 3'b111);
    misalignReq = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   misalignReq = bus.addr[0];
      2'b10:   misalignReq = |bus.addr[1:0];
      2'b11:   misalignReq = |bus.addr[2:0];
      default: misalignReq = 1'b0;
    endcase
    errReq = illegalReq | misalignReq;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      OCIOSO: begin
        if (bus.req) begin
          if (errReq)
            stateNext = CONCLUI;
          else if (bus.we && (bus.funct3[1:0] == 2'b11))
            stateNext = ESCRITA;
          else
            stateNext = LEITURA;
        end
      end
      LEITURA: stateNext = weReg ? ESCRITA : CONCLUI;
      ESCRITA: stateNext = CONCLUI;
      CONCLUI: stateNext = OCIOSO;
      default: stateNext = OCIOSO;
    endcase
  end

  // Load lane extraction: move the addressed lane to bit 0, then extend by funct3.
  always_comb begin
    shiftedWord = doutDM >> {offReg, 3'b000};
    case (funct3Reg)
      3'b000:  loadValue = {{(LARGURA-8){shiftedWord[7]}},   shiftedWord[7:0]};
      3'b001:  loadValue = {{(LARGURA-16){shiftedWord[15]}}, shiftedWord[15:0]};
      3'b010:  loadValue = {{(LARGURA-32){shiftedWord[31]}}, shiftedWord[31:0]};
      3'b100:  loadValue = {{(LARGURA-8){1'b0}},  shiftedWord[7:0]};
      3'b101:  loadValue = {{(LARGURA-16){1'b0}}, shiftedWord[15:0]};
      3'b110:  loadValue = {{(LARGURA-32){1'b0}}, shiftedWord[31:0]};
      default: loadValue = shiftedWord;
    endcase
  end

  // Store merge: each byte lane decides whether it is covered by the store and which
  // byte of wdata lands there (the low bytes of wdata, indexed by lane within the size).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [2:0] LANE = 3'(gi);
      localparam int         B1   = (gi % 2) * 8;
      localparam int         B2   = (gi % 4) * 8;
      logic       laneHit;
      logic [7:0] srcByte;

      always_comb begin
        laneHit = 1'b0;
        srcByte = wdataReg[8*gi +: 8];
        case (funct3Reg[1:0])
          2'b00: begin
            laneHit = (offReg == LANE);
            srcByte = wdataReg[7:0];
          end
          2'b01: begin
            laneHit = (offReg[2:1] == LANE[2:1]);
            srcByte = wdataReg[B1 +: 8];
          end
          2'b10: begin
            laneHit = (offReg[2] == LANE[2]);
            srcByte = wdataReg[B2 +: 8];
          end
          default: begin
            laneHit = 1'b1;
            srcByte = wdataReg[8*gi +: 8];
          end
        endcase
      end

      assign mergedWord[8*gi +: 8] = laneHit ? srcByte : doutDM[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= OCIOSO;
      weReg     <= 1'b0;
      funct3Reg <= 3'b000;
      offReg    <= 3'b000;
      wdataReg  <= '0;
      erroReg   <= 1'b0;
      rdataReg  <= '0;
      addrDMReg <= '0;
      dinDMReg  <= '0;
    end else begin
      stateReg <= stateNext;
      case (stateReg)
        OCIOSO: begin
          if (bus.req) begin
            weReg     <= bus.we;
            funct3Reg <= bus.funct3;
            offReg    <= bus.addr[2:0];
            wdataReg  <= bus.wdata;
            erroReg   <= errReq;
            // Errored requests never reach memory, so addrDM keeps its previous value.
            if (!errReq) begin
              addrDMReg <= bus.addr[ADDR_DM+2:3];
              if (bus.we && (bus.funct3[1:0] == 2'b11))
                dinDMReg <= bus.wdata;
            end
          end
        end
        LEITURA: begin
          if (weReg)
            dinDMReg <= mergedWord;
          else
            rdataReg <= loadValue;
        end
        default: ;
      endcase
    end
  end

  // Reset gates the strobes combinationally so a reset during ESCRITA drops the write.
  assign WeDM      = (stateReg == ESCRITA) && !reset;
  assign bus.ready = (stateReg == CONCLUI) && !reset;
  assign bus.erro  = bus.ready && erroReg;
  assign bus.rdata = rdataReg;
  assign addrDM    = addrDMReg;
  assign dinDM     = dinDMReg;

endmodule

// File: tb/tb_interface_load_store.sv
// Scoreboard bench for interface_load_store: stimulus pushes expected responses and
// memory writes; a negedge monitor pops and compares them as the DUT produces them.
module tb_interface_load_store;

  logic        clk;
  logic        reset;
  logic [4:0]  addrDM;
  logic        WeDM;
  logic [63:0] dinDM;
  logic [63:0] doutDM;
  logic [63:0] mem [0:31];

  interface_load_store_if #(.LARGURA(64)) bus ();

  interface_load_store #(.ADDR_DM(5), .LARGURA(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .addrDM (addrDM),
    .WeDM   (WeDM),
    .dinDM  (dinDM),
    .doutDM (doutDM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign doutDM = mem[addrDM];
  always @(posedge clk) if (WeDM) mem[addrDM] <= dinDM;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        erro;
    logic [63:0] rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  rsp_t rspQ[$];
  wr_t  wrQ[$];

  int checks = 0;
  int errors = 0;
  logic [63:0] expRdata = 64'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse and every write strobe must match a queued expectation.
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      if (rspQ.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = rspQ.pop_front();
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
        check("erro", {63'd0, bus.erro}, {63'd0, e.erro});
        check("rdata", bus.rdata, e.rdata);
        $display("ready  cycle=%0d erro=%0b rdata=0x%016h", cyc, bus.erro, bus.rdata);
      end
    end else if (bus.erro !== 1'b0) begin
      check("erro_without_ready", {63'd0, bus.erro}, 64'd0);
    end
    if (WeDM === 1'b1) begin
      if (wrQ.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t w;
        w = wrQ.pop_front();
        check("write_cycle", 64'(cyc), 64'(w.cyc));
        check("addrDM", 64'(addrDM), 64'(w.idx));
        check("dinDM", dinDM, w.data);
        $display("write  cycle=%0d addrDM=%0d dinDM=0x%016h", cyc, addrDM, dinDM);
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while ((rspQ.size() != 0 || wrQ.size() != 0) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rspQ.size() != 0 || wrQ.size() != 0) begin
      check("timeout_pending", 64'(rspQ.size() + wrQ.size()), 64'd0);
      rspQ.delete();
      wrQ.delete();
    end
  endtask

  // One request, req held for exactly one cycle in OCIOSO.
  task automatic issue(input logic iwe, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input int lat, input logic expErr,
                       input logic [63:0] newRdata, input bit doWrite,
                       input logic [63:0] wrData, input int wrLat);
    rsp_t e;
    wr_t  w;
    @(posedge clk);
    #1;
    bus.req    = 1'b1;
    bus.we     = iwe;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = wd;
    if (doWrite) begin
      w.idx  = a[7:3];
      w.data = wrData;
      w.cyc  = cyc + wrLat;
      wrQ.push_back(w);
    end
    e.erro  = expErr;
    e.rdata = newRdata;
    e.cyc   = cyc + lat;
    rspQ.push_back(e);
    expRdata = newRdata;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    waitIdle();
  endtask

  task automatic doLoad(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] v);
    issue(1'b0, f3, a, 64'h0, 2, 1'b0, v, 1'b0, 64'h0, 0);
  endtask

  task automatic doStore(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] merged);
    int lat;
    lat = (f3 == 3'b011) ? 2 : 3;
    issue(1'b1, f3, a, wd, lat, 1'b0, expRdata, 1'b1, merged, lat - 1);
  endtask

  task automatic doErr(input logic iwe, input logic [2:0] f3, input logic [63:0] a);
    issue(iwe, f3, a, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, expRdata, 1'b0, 64'h0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ready"},  {63'd0, bus.ready}, 64'd0);
    check({tag, "_erro"},   {63'd0, bus.erro},  64'd0);
    check({tag, "_rdata"},  bus.rdata,          64'd0);
    check({tag, "_addrDM"}, 64'(addrDM),        64'd0);
    check({tag, "_WeDM"},   {63'd0, WeDM},      64'd0);
    check({tag, "_dinDM"},  dinDM,              64'd0);
  endtask

  initial begin
    logic [63:0] holdA;
    logic [63:0] holdB;
    holdA = 64'h1111_2222_3333_4444;
    holdB = 64'h5555_6666_7777_8888;

    for (int i = 0; i < 32; i++) mem[i] = 64'h0;
    mem[1] = 64'h8877_6655_4433_2211;
    mem[4] = 64'h0102_0304_0506_0708;

    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
    bus.addr = 64'h0; bus.wdata = 64'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetOutputs("reset");

    // Loads from mem[1] = 0x8877665544332211
    doLoad(3'b000, 64'h0F, 64'hFFFF_FFFF_FFFF_FF88);   // LB
    doLoad(3'b100, 64'h0F, 64'h0000_0000_0000_0088);   // LBU
    doLoad(3'b001, 64'h0E, 64'hFFFF_FFFF_FFFF_8877);   // LH
    doLoad(3'b010, 64'h0C, 64'hFFFF_FFFF_8877_6655);   // LW
    doLoad(3'b110, 64'h0C, 64'h0000_0000_8877_6655);   // LWU
    doLoad(3'b101, 64'h0A, 64'h0000_0000_0000_4433);   // LHU

    // Stores
    doStore(3'b001, 64'h0A, 64'h0000_0000_0000_BEEF, 64'h8877_6655_BEEF_2211);  // SH
    doLoad(3'b011, 64'h08, 64'h8877_6655_BEEF_2211);                            // LD
    doStore(3'b011, 64'h10, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);  // SD
    doLoad(3'b011, 64'h10, 64'h0123_4567_89AB_CDEF);

    // Misaligned and illegal requests
    doErr(1'b0, 3'b010, 64'h0A);   // LW misaligned
    doErr(1'b1, 3'b011, 64'h14);   // SD misaligned
    doErr(1'b1, 3'b100, 64'h10);   // illegal store
    doErr(1'b0, 3'b111, 64'h10);   // illegal load
    doErr(1'b0, 3'b001, 64'h0F);   // LH misaligned

    doStore(3'b010, 64'h14, 64'hCAFE_BABE_DEAD_BEEF, 64'hDEAD_BEEF_89AB_CDEF);  // SW upper
    doStore(3'b000, 64'h11, 64'h0000_0000_0000_00AA, 64'hDEAD_BEEF_89AB_AAEF);  // SB lane 1
    doLoad(3'b000, 64'h11, 64'hFFFF_FFFF_FFFF_FFAA);
    doLoad(3'b100, 64'h16, 64'h0000_0000_0000_00AD);                            // LBU lane 6

    // req held high with alternating SD/LD: one acceptance every three cycles.
    @(posedge clk);
    #1;
    bus.req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rsp_t e;
      wr_t  w;
      bus.we     = (k % 2 == 0);
      bus.funct3 = 3'b011;
      bus.addr   = 64'h18;
      bus.wdata  = (k < 2) ? holdA : holdB;
      if (k % 2 == 0) begin
        w.idx  = 5'd3;
        w.data = bus.wdata;
        w.cyc  = cyc + 1;
        wrQ.push_back(w);
      end else begin
        expRdata = (k < 2) ? holdA : holdB;
      end
      e.erro  = 1'b0;
      e.rdata = expRdata;
      e.cyc   = cyc + 2;
      rspQ.push_back(e);
      repeat (3) @(posedge clk);
      #1;
    end
    bus.req = 1'b0;
    waitIdle();

    // Reset asserted while a byte store sits in ESCRITA; address 0x121 wraps to index 4.
    @(posedge clk);
    #1;
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000;
    bus.addr = 64'h121; bus.wdata = 64'h55;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    check("rst_leitura_addrDM", 64'(addrDM), 64'd4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_escrita_WeDM", {63'd0, WeDM}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetOutputs("midreset");
    check("rst_mem4_unchanged", mem[4], 64'h0102_0304_0506_0708);
    repeat (4) @(posedge clk);
    expRdata = 64'h0;

    // Block is idle again: a load to the wrapped address completes with normal latency.
    doLoad(3'b011, 64'h120, 64'h0102_0304_0506_0708);

    check("mem1_final", mem[1], 64'h8877_6655_BEEF_2211);
    check("mem2_final", mem[2], 64'hDEAD_BEEF_89AB_AAEF);
    check("mem3_final", mem[3], holdB);
    check("mem4_final", mem[4], 64'h0102_0304_0506_0708);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
